// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/bubble/flush controller with cache-miss wait and timeout watchdog.
// Optional performance counters are enabled with PIPE_STALL_PERF_CNT_EN.
module pipe_stall_ctrl #(
  parameter int                  NUM_REGS   = 5,
  parameter int                  HAZ_STAGE  = 1,
  parameter logic [NUM_REGS-1:0] FLUSH_MASK = 5'b00010,
  parameter int                  TMO_W      = 8
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                hazard,
  input  logic                flush_req,
  input  logic                imem_miss,
  input  logic                dmem_miss,
  input  logic                mem_rd,
  input  logic                mem_wr,
  input  logic                mem_ready,
  output logic [NUM_REGS-1:0] stall,
  output logic                nop,
  output logic [NUM_REGS-1:0] flush,
  output logic                miss_tmo,
  output logic [31:0]         perf_stall_cyc,
  output logic [31:0]         perf_bubbles,
  output logic [31:0]         perf_flushes
);

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_ERR} state_t;

  localparam logic [TMO_W-1:0] CNT_MAX = '1;

  state_t              state_q, state_d;
  logic [TMO_W-1:0]    cnt_q, cnt_d;
  logic                miss_tmo_q, miss_tmo_d;
  logic [NUM_REGS-1:0] haz_mask;
  logic [NUM_REGS-1:0] stall_c, flush_c;
  logic                nop_c, mem_haz;

  // Registers up to and including HAZ_STAGE freeze on a load-use hazard.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_haz_mask
    assign haz_mask[gi] = (gi <= HAZ_STAGE);
  end

  assign mem_haz = imem_miss | (dmem_miss & (mem_rd | mem_wr));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    miss_tmo_d = miss_tmo_q;
    stall_c    = '0;
    nop_c      = 1'b0;
    flush_c    = '0;
    case (state_q)
      ST_RUN: begin
        if (mem_haz) begin
          stall_c = '1;
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else if (flush_req) begin
          flush_c = FLUSH_MASK;
        end else if (hazard) begin
          stall_c = haz_mask;
          nop_c   = 1'b1;
        end
      end
      ST_WAIT: begin
        stall_c = '1;
        cnt_d   = cnt_q + 1'b1;
        // A refill arriving on the terminal count still wins over the timeout.
        if (mem_ready) begin
          state_d = ST_RUN;
        end else if (cnt_d == CNT_MAX) begin
          state_d    = ST_ERR;
          miss_tmo_d = 1'b1;
        end
      end
      ST_ERR: begin
        stall_c = '1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      miss_tmo_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      miss_tmo_q <= miss_tmo_d;
    end
  end

  // Outputs read as idle for the whole reset cycle, whatever state is being left.
  assign stall    = Rst ? '0 : stall_c;
  assign flush    = Rst ? '0 : flush_c;
  assign nop      = nop_c & ~Rst;
  assign miss_tmo = miss_tmo_q & ~Rst;

`ifdef PIPE_STALL_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_bub_q, perf_bub_d;
  logic [31:0] perf_fl_q, perf_fl_d;

  always_comb begin
    perf_stall_d = perf_stall_q + {31'd0, stall_c[0]};
    perf_bub_d   = perf_bub_q + {31'd0, nop_c};
    perf_fl_d    = perf_fl_q + {31'd0, |flush_c};
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      perf_stall_q <= '0;
      perf_bub_q   <= '0;
      perf_fl_q    <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_bub_q   <= perf_bub_d;
      perf_fl_q    <= perf_fl_d;
    end
  end

  assign perf_stall_cyc = Rst ? '0 : perf_stall_q;
  assign perf_bubbles   = Rst ? '0 : perf_bub_q;
  assign perf_flushes   = Rst ? '0 : perf_fl_q;
`else
  assign perf_stall_cyc = '0;
  assign perf_bubbles   = '0;
  assign perf_flushes   = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: a default instance and a 7-register, 3-bit-timeout
// instance share stimulus; a rule-level model predicts each cycle's outputs.
module tb_pipe_stall_ctrl;

`ifdef PIPE_STALL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic hazard = 0, flush_req = 0, imem_miss = 0, dmem_miss = 0;
  logic mem_rd = 0, mem_wr = 0, mem_ready = 0;

  logic [4:0]  stall_a, flush_a;
  logic        nop_a, tmo_a;
  logic [31:0] ps_a, pb_a, pf_a;
  logic [6:0]  stall_b, flush_b;
  logic        nop_b, tmo_b;
  logic [31:0] ps_b, pb_b, pf_b;

  always #5 Clk = ~Clk;

  pipe_stall_ctrl u_dut (
    .Clk(Clk), .Rst(Rst), .hazard(hazard), .flush_req(flush_req),
    .imem_miss(imem_miss), .dmem_miss(dmem_miss), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_ready(mem_ready), .stall(stall_a), .nop(nop_a), .flush(flush_a),
    .miss_tmo(tmo_a), .perf_stall_cyc(ps_a), .perf_bubbles(pb_a), .perf_flushes(pf_a)
  );

  pipe_stall_ctrl #(
    .NUM_REGS(7), .HAZ_STAGE(2), .FLUSH_MASK(7'b0000110), .TMO_W(3)
  ) u_dut7 (
    .Clk(Clk), .Rst(Rst), .hazard(hazard), .flush_req(flush_req),
    .imem_miss(imem_miss), .dmem_miss(dmem_miss), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_ready(mem_ready), .stall(stall_b), .nop(nop_b), .flush(flush_b),
    .miss_tmo(tmo_b), .perf_stall_cyc(ps_b), .perf_bubbles(pb_b), .perf_flushes(pf_b)
  );

  typedef struct {
    int          cyc;
    logic [6:0]  stall;
    logic        nop;
    logic [6:0]  flush;
    logic        tmo;
    logic [31:0] ps, pb, pf;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  // Per-instance configuration and model state.
  int         p_n[2]    = '{5, 7};
  int         p_hs[2]   = '{1, 2};
  logic [6:0] p_mask[2] = '{7'b0000010, 7'b0000110};
  int         p_tmax[2] = '{255, 7};
  bit         waiting[2];
  bit         failed[2];
  int         waited[2];
  logic [31:0] n_stall[2], n_bub[2], n_fl[2];

  task automatic check(input string name, input int cyc, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  task automatic model_step(input int k, input logic rst, input logic haz, input logic fl,
                            input logic im, input logic dm, input logic rd, input logic wr,
                            input logic rdy);
    exp_t e;
    logic [6:0] all_ones;
    logic mh;
    all_ones = 7'((1 << p_n[k]) - 1);
    mh = im | (dm & (rd | wr));
    e.cyc = cyc_n; e.stall = '0; e.nop = 0; e.flush = '0; e.tmo = 0;
    e.ps = '0; e.pb = '0; e.pf = '0;
    if (rst) begin
      waiting[k] = 0; failed[k] = 0; waited[k] = 0;
      n_stall[k] = 0; n_bub[k] = 0; n_fl[k] = 0;
    end else begin
      e.tmo = failed[k];
      if (PERF) begin
        e.ps = n_stall[k]; e.pb = n_bub[k]; e.pf = n_fl[k];
      end
      if (failed[k]) begin
        e.stall = all_ones;
      end else if (waiting[k]) begin
        e.stall = all_ones;
        waited[k]++;
        if (rdy) waiting[k] = 0;
        else if (waited[k] == p_tmax[k]) begin
          waiting[k] = 0;
          failed[k]  = 1;
        end
      end else if (mh) begin
        e.stall = all_ones;
        waiting[k] = 1;
        waited[k]  = 0;
      end else if (fl) begin
        e.flush = p_mask[k];
      end else if (haz) begin
        e.stall = 7'((1 << (p_hs[k] + 1)) - 1);
        e.nop   = 1;
      end
      if (e.stall[0]) n_stall[k]++;
      if (e.nop) n_bub[k]++;
      if (e.flush != 0) n_fl[k]++;
    end
    if (k == 0) q_a.push_back(e);
    else q_b.push_back(e);
  endtask

  task automatic drive(input logic rst, input logic haz, input logic fl, input logic im,
                       input logic dm, input logic rd, input logic wr, input logic rdy);
    @(posedge Clk);
    #1;
    cyc_n++;
    Rst = rst; hazard = haz; flush_req = fl; imem_miss = im;
    dmem_miss = dm; mem_rd = rd; mem_wr = wr; mem_ready = rdy;
    model_step(0, rst, haz, fl, im, dm, rd, wr, rdy);
    model_step(1, rst, haz, fl, im, dm, rd, wr, rdy);
  endtask

  // Monitor: outputs are meaningful every cycle, so every pending expectation is compared
  // on the falling edge following its stimulus.
  always @(negedge Clk) begin
    exp_t e;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      check("a.stall", e.cyc, 32'(stall_a), 32'(e.stall));
      check("a.nop", e.cyc, 32'(nop_a), 32'(e.nop));
      check("a.flush", e.cyc, 32'(flush_a), 32'(e.flush));
      check("a.miss_tmo", e.cyc, 32'(tmo_a), 32'(e.tmo));
      check("a.perf_stall", e.cyc, ps_a, e.ps);
      check("a.perf_bub", e.cyc, pb_a, e.pb);
      check("a.perf_fl", e.cyc, pf_a, e.pf);
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      check("b.stall", e.cyc, 32'(stall_b), 32'(e.stall));
      check("b.nop", e.cyc, 32'(nop_b), 32'(e.nop));
      check("b.flush", e.cyc, 32'(flush_b), 32'(e.flush));
      check("b.miss_tmo", e.cyc, 32'(tmo_b), 32'(e.tmo));
      check("b.perf_stall", e.cyc, ps_b, e.ps);
      check("b.perf_bub", e.cyc, pb_b, e.pb);
      check("b.perf_fl", e.cyc, pf_b, e.pf);
    end
  end

  initial begin
    // Reset, then a two-cycle load-use hazard.
    repeat (2) drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) drive(0, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    // Flush overrides a simultaneous hazard.
    drive(0, 1, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    // D-cache read miss, refill pulse four cycles later.
    drive(0, 0, 0, 0, 1, 1, 0, 0);
    repeat (3) drive(0, 1, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    // D-cache miss without a memory access is ignored.
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    // Back-to-back misses: re-entry on the first free cycle.
    drive(0, 0, 0, 0, 1, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    // Held I-cache miss with no refill: both instances time out and stay stalled.
    repeat (270) drive(0, 1, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    // Randomised traffic with rare resets.
    for (int i = 0; i < 2500; i++) begin
      drive(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 2),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
            1'($urandom), 1'($urandom), ($urandom_range(0, 9) < 2));
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge Clk);
    check("drain_a", cyc_n, 32'(q_a.size()), 32'd0);
    check("drain_b", cyc_n, 32'(q_b.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
